baud_tick_gen: RTL and testbench

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/baud_tick_gen_if.sv | 27 ++
 rtl/baud_tick_gen.sv | 108 ++++++++++
 tb/tb_baud_tick_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_gen_if.sv
// Control/status bundle for baud_tick_gen: run/resync/divisor-load inputs
// and the tick, baud-clock and config-handshake outputs.
interface baud_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              enable;
    logic              resync;
    logic              cfg_load;
    logic [DIV_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic              os_tick;
    logic              bit_tick;
    logic              baud_clk;
    logic              cfg_pend;
    logic              cfg_ack;

    modport master (
        output enable, resync, cfg_load, cfg_int, cfg_frac,
        input  os_tick, bit_tick, baud_clk, cfg_pend, cfg_ack
    );

    modport slave (
        input  enable, resync, cfg_load, cfg_int, cfg_frac,
        output os_tick, bit_tick, baud_clk, cfg_pend, cfg_ack
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: oversample ticks from an int.frac divisor,
// bit ticks every OVERSAMPLE os ticks, divisor swaps only on bit boundaries.
module baud_tick_gen #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int RST_INT    = 325,
    parameter int RST_FRAC   = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    baud_tick_gen_if.slave bus
);
    localparam int OSC_W = $clog2(OVERSAMPLE);
    localparam int CYC_W = DIV_W + 1;

    logic [DIV_W-1:0]  r_act_int, r_pend_int;
    logic [FRAC_W-1:0] r_act_frac, r_pend_frac, r_acc;
    logic [CYC_W-1:0]  r_cyc, r_per;
    logic [OSC_W-1:0]  r_osc;
    logic              r_term, r_baud, r_cfg_pend, r_cfg_ack;

    logic [DIV_W-1:0]  w_eff;
    logic [FRAC_W:0]   w_sum;
    logic [CYC_W-1:0]  w_per_new, w_per, w_cyc_nxt;
    logic [OSC_W-1:0]  w_osc_nxt;
    logic              w_start, w_run, w_os, w_bit, w_apply, w_term_nxt;

    assign w_eff     = (r_act_int < DIV_W'(2)) ? DIV_W'(2) : r_act_int;
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_act_frac};
    assign w_per_new = CYC_W'(w_eff) + CYC_W'(w_sum[FRAC_W]);
    assign w_start   = (r_cyc == '0);
    // The period is fixed on its first cycle; r_per is stale until then.
    assign w_per     = w_start ? w_per_new : r_per;
    assign w_run     = bus.enable & ~bus.resync;
    assign w_os      = w_run & r_term;
    assign w_bit     = w_os & (r_osc == OSC_W'(OVERSAMPLE - 1));
    assign w_apply   = w_bit | ~bus.enable | bus.resync;

    // Next counter state; disabled or resync cycles restart the phase.
    always_comb begin
        w_cyc_nxt  = '0;
        w_term_nxt = 1'b0;
        w_osc_nxt  = '0;
        if (w_run) begin
            w_cyc_nxt  = r_term ? '0 : r_cyc + CYC_W'(1);
            w_term_nxt = ~r_term && (r_cyc + CYC_W'(1) == w_per - CYC_W'(1));
            w_osc_nxt  = w_os ? r_osc + OSC_W'(1) : r_osc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc  <= '0;
            r_per  <= '0;
            r_acc  <= '0;
            r_osc  <= '0;
            r_term <= 1'b0;
            r_baud <= 1'b0;
        end else begin
            r_cyc  <= w_cyc_nxt;
            r_osc  <= w_osc_nxt;
            r_term <= w_term_nxt;
            r_baud <= (w_osc_nxt < OSC_W'(OVERSAMPLE / 2));
            if (!w_run)
                r_acc <= '0;
            else if (w_start) begin
                r_acc <= w_sum[FRAC_W-1:0];
                r_per <= w_per_new;
            end
        end
    end

    // A load landing on an application point bypasses the pending slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_act_int   <= DIV_W'(RST_INT);
            r_act_frac  <= FRAC_W'(RST_FRAC);
            r_pend_int  <= '0;
            r_pend_frac <= '0;
            r_cfg_pend  <= 1'b0;
            r_cfg_ack   <= 1'b0;
        end else begin
            r_cfg_ack <= 1'b0;
            if (w_apply && bus.cfg_load) begin
                r_act_int  <= bus.cfg_int;
                r_act_frac <= bus.cfg_frac;
                r_cfg_pend <= 1'b0;
                r_cfg_ack  <= 1'b1;
            end else if (w_apply && r_cfg_pend) begin
                r_act_int  <= r_pend_int;
                r_act_frac <= r_pend_frac;
                r_cfg_pend <= 1'b0;
                r_cfg_ack  <= 1'b1;
            end else if (bus.cfg_load) begin
                r_pend_int  <= bus.cfg_int;
                r_pend_frac <= bus.cfg_frac;
                r_cfg_pend  <= 1'b1;
            end
        end
    end

    assign bus.os_tick  = w_os;
    assign bus.bit_tick = w_bit;
    assign bus.baud_clk = bus.enable & r_baud;
    assign bus.cfg_pend = r_cfg_pend;
    assign bus.cfg_ack  = r_cfg_ack;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: event-time reference model checked every cycle,
// a divisor table, directed corner sequences and a random soak.
module tb_baud_tick_gen;
    localparam int OS = 16;
    localparam int FS = 16;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    baud_tick_gen_if #(.DIV_W(16), .FRAC_W(4)) bif();
    baud_tick_gen #(.DIV_W(16), .FRAC_W(4), .OVERSAMPLE(16), .RST_INT(325), .RST_FRAC(8))
        dut (.clock(clock), .reset_n(reset_n), .bus(bif));

    int n_chk = 0, n_fail = 0, tcyc = 0;
    logic [4:0] obs, expv;   // {os_tick, bit_tick, baud_clk, cfg_pend, cfg_ack}

    // Reference: divisor registers plus "cycles left until the next tick".
    int m_int, m_frac, m_pint, m_pfrac, m_acc, m_osc, m_left;
    bit m_pend, m_ack, m_fresh, m_bq;

    typedef struct { int ci; int cf; int first; int span; int high; } vec_t;
    vec_t vt[6];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_int = 325; m_frac = 8; m_pint = 0; m_pfrac = 0;
        m_acc = 0; m_osc = 0; m_left = 0;
        m_pend = 0; m_ack = 0; m_fresh = 1; m_bq = 0;
    endtask

    task automatic model_step(input bit en, input bit rs, input bit ld,
                              input int ci, input int cf, output logic [4:0] o);
        bit os, bt, ap;
        os = 0;
        if (en && !rs) begin
            if (m_fresh) begin
                m_left  = ((m_int < 2) ? 2 : m_int) + ((m_acc + m_frac >= FS) ? 1 : 0);
                m_acc   = (m_acc + m_frac) % FS;
                m_fresh = 0;
            end
            os = (m_left == 1);
        end
        bt = os && (m_osc == OS - 1);
        o  = {os, bt, en && m_bq, m_pend, m_ack};
        ap = bt || !en || rs;
        m_ack = 0;
        if (ap && ld) begin
            m_int = ci; m_frac = cf; m_ack = 1; m_pend = 0;
        end else if (ap && m_pend) begin
            m_int = m_pint; m_frac = m_pfrac; m_ack = 1; m_pend = 0;
        end else if (ld) begin
            m_pint = ci; m_pfrac = cf; m_pend = 1;
        end
        if (!en || rs) begin
            m_fresh = 1; m_acc = 0; m_osc = 0;
        end else begin
            if (os) m_osc = (m_osc + 1) % OS;
            m_left--;
            if (m_left == 0) m_fresh = 1;
        end
        m_bq = (m_osc < OS / 2);
    endtask

    // One clock: drive just after posedge, compare at negedge against the model.
    task automatic step(input bit en, input bit rs, input bit ld, input int ci, input int cf);
        bif.enable   = en;
        bif.resync   = rs;
        bif.cfg_load = ld;
        bif.cfg_int  = 16'(ci);
        bif.cfg_frac = 4'(cf);
        @(negedge clock);
        model_step(en, rs, ld, ci, cf, expv);
        obs = {bif.os_tick, bif.bit_tick, bif.baud_clk, bif.cfg_pend, bif.cfg_ack};
        tcyc++;
        check($sformatf("cycle %0d outputs", tcyc), 32'(obs), 32'(expv));
        @(posedge clock);
        #1;
    endtask

    task automatic fresh_cfg(input int ci, input int cf);
        step(0, 0, 1, ci, cf);
        step(0, 0, 0, 0, 0);
        tcyc = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        obs = {bif.os_tick, bif.bit_tick, bif.baud_clk, bif.cfg_pend, bif.cfg_ack};
        check("outputs in reset", 32'(obs), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int first, span, cnt, high, sbit;
        vt[0] = '{ci: 4, cf: 0,  first: 4, span: 64, high: 32};
        vt[1] = '{ci: 4, cf: 8,  first: 4, span: 72, high: 36};
        vt[2] = '{ci: 1, cf: 0,  first: 2, span: 32, high: 16};
        vt[3] = '{ci: 0, cf: 0,  first: 2, span: 32, high: 16};
        vt[4] = '{ci: 3, cf: 15, first: 3, span: 63, high: 31};
        vt[5] = '{ci: 6, cf: 1,  first: 6, span: 97, high: 48};

        reset_n = 1'b0;
        bif.enable = 1'b1; bif.resync = 1'b0; bif.cfg_load = 1'b0;
        bif.cfg_int = '0; bif.cfg_frac = '0;
        model_reset();
        @(posedge clock);
        #1;
        do_reset();
        bif.enable = 1'b0;

        // Divisor table: first tick, 16-tick span, bit_tick on 16th, baud high time.
        foreach (vt[r]) begin
            fresh_cfg(vt[r].ci, vt[r].cf);
            first = -1; span = -1; cnt = 0; high = 0; sbit = 0;
            for (int k = 0; k < 200 && span < 0; k++) begin
                step(1, 0, 0, 0, 0);
                if (obs[2]) high++;
                if (obs[4]) begin
                    cnt++;
                    if (cnt == 1) first = tcyc;
                    if (cnt == 16) begin span = tcyc; sbit = obs[3]; end
                end
            end
            check($sformatf("row%0d first os_tick", r), first, vt[r].first);
            check($sformatf("row%0d 16 os_tick span", r), span, vt[r].span);
            check($sformatf("row%0d bit_tick on 16th", r), sbit, 1);
            check($sformatf("row%0d baud_clk high", r), high, vt[r].high);
        end

        // Mid-bit reload at the 5th os_tick.
        fresh_cfg(4, 0);
        for (int c = 1; c <= 80; c++) begin
            step(1, 0, c == 20, 8, 0);
            if (c == 21) check("reload pend set", obs[1], 1);
            if (c == 64) check("reload bit+pend", {obs[3], obs[1]}, 2'b11);
            if (c == 65) check("reload ack/pend", {obs[0], obs[1]}, 2'b10);
            if (c == 68) check("reload no old tick", obs[4], 0);
            if (c == 72) check("reload new period", obs[4], 1);
        end

        // Resync on a terminal-count cycle.
        fresh_cfg(4, 0);
        for (int c = 1; c <= 80; c++) begin
            step(1, c == 12, 0, 0, 0);
            if (c == 12) check("resync suppress", obs[4], 0);
            if (c == 15) check("resync early", obs[4], 0);
            if (c == 16) check("resync next tick", obs[4], 1);
            if (c == 72) check("resync old bit", obs[3], 0);
            if (c == 76) check("resync bit restart", obs[3], 1);
        end

        // Enable drop with a pending divisor.
        fresh_cfg(4, 0);
        for (int c = 1; c <= 30; c++) begin
            step(!(c >= 11 && c <= 13), 0, c == 10, 5, 0);
            if (c >= 11 && c <= 13) check($sformatf("disabled outs c%0d", c), obs[4:2], 3'b000);
            if (c == 11) check("disabled pend", obs[1], 1);
            if (c == 12) check("disabled ack", {obs[0], obs[1]}, 2'b10);
            if (c == 17) check("reenable early", obs[4], 0);
            if (c == 18) check("reenable first tick", obs[4], 1);
        end

        // Reset with a pending divisor restores 325.8 and drops the pending value.
        fresh_cfg(4, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 7, 0);
        step(1, 0, 0, 0, 0);
        check("pre-reset pend", obs[1], 1);
        do_reset();
        tcyc = 0;
        for (int c = 1; c <= 660; c++) begin
            step(1, 0, 0, 0, 0);
            if (c == 1) check("post-reset pend", obs[1], 0);
            if (c == 324) check("post-reset early", obs[4], 0);
            if (c == 325) check("post-reset first tick", obs[4], 1);
            if (c == 651) check("post-reset second tick", obs[4], 1);
        end

        // Random soak against the reference model.
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 99) < 96, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 9), $urandom_range(0, 15));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
